ray_dir_gen: RTL

Downstream consumer of the POV vectors. Once per frame it snapshots facing/vplane and emits one ray direction per screen column: rayDir(i) = facing + vplane*(2i/NUM_RAYS - 1), for i = 0..NUM_RAYS-1.
It builds each ray by incremental accumulation (add a shifted vplane step), so it needs no multiplier. It feeds the ray tracer/DDA stage through a valid/ready handshake.
The snapshot isolates the tracer from POV loads that land mid-frame.

---
 rtl/ray_dir_gen_pkg.sv | 15 +
 rtl/ray_dir_gen_vec2_accum.sv | 31 +++
 rtl/ray_dir_gen.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ray_dir_gen_pkg.sv
// Shared fixed-point widths and FSM encoding for the ray direction generator.
// The state encoding is also used by the tracer's debug bus.
package ray_dir_gen_pkg;

    localparam int unsigned QM    = 10;
    localparam int unsigned QN    = 10;
    localparam int unsigned RAY_W = QM + QN;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage : ray_dir_gen_pkg

// File: rtl/ray_dir_gen_vec2_accum.sv
// Two-component W-bit accumulator: load a start vector, then add a step vector
// once per enabled cycle. Wraps silently in two's complement.
module ray_dir_gen_vec2_accum #(
    parameter int unsigned W = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         add,
    input  logic [W-1:0] load_x,
    input  logic [W-1:0] load_y,
    input  logic [W-1:0] step_x,
    input  logic [W-1:0] step_y,
    output logic [W-1:0] x,
    output logic [W-1:0] y
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (load) begin
            x <= load_x;
            y <= load_y;
        end else if (add) begin
            x <= x + step_x;
            y <= y + step_y;
        end
    end

endmodule : ray_dir_gen_vec2_accum

// File: rtl/ray_dir_gen.sv
// Per-frame ray direction generator: snapshots facing/vplane on i_start and
// streams facing + vplane*(2i/NUM_RAYS - 1) for every column over valid/ready.
module ray_dir_gen
    import ray_dir_gen_pkg::*;
#(
    parameter int unsigned LOG2_RAYS = 3,
    parameter int unsigned W         = RAY_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [W-1:0]         i_facingX,
    input  logic [W-1:0]         i_facingY,
    input  logic [W-1:0]         i_vplaneX,
    input  logic [W-1:0]         i_vplaneY,
    output logic [W-1:0]         o_rayX,
    output logic [W-1:0]         o_rayY,
    output logic [LOG2_RAYS-1:0] o_ray_idx,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_busy,
    output logic                 o_frame_done
);

    localparam logic [LOG2_RAYS-1:0] LAST_IDX = '1;

    state_t state, state_nx;

    logic [W-1:0] facing_x_q, facing_y_q;
    logic [W-1:0] vplane_x_q, vplane_y_q;
    logic [W-1:0] step_x_q, step_y_q;

    logic                 accept;
    logic                 snap_en;
    logic                 acc_load;
    logic                 acc_add;
    logic                 valid_nx;
    logic                 busy_nx;
    logic                 done_nx;
    logic [LOG2_RAYS-1:0] idx_nx;

    assign accept = o_valid && i_ready;

    // Frame snapshot; the step is vplane / (NUM_RAYS/2), truncating toward -inf.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            facing_x_q <= '0;
            facing_y_q <= '0;
            vplane_x_q <= '0;
            vplane_y_q <= '0;
            step_x_q   <= '0;
            step_y_q   <= '0;
        end else if (snap_en) begin
            facing_x_q <= i_facingX;
            facing_y_q <= i_facingY;
            vplane_x_q <= i_vplaneX;
            vplane_y_q <= i_vplaneY;
            step_x_q   <= W'($signed(i_vplaneX) >>> (LOG2_RAYS - 1));
            step_y_q   <= W'($signed(i_vplaneY) >>> (LOG2_RAYS - 1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            o_valid      <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_ray_idx    <= '0;
        end else begin
            state        <= state_nx;
            o_valid      <= valid_nx;
            o_busy       <= busy_nx;
            o_frame_done <= done_nx;
            o_ray_idx    <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        valid_nx = o_valid;
        idx_nx   = o_ray_idx;
        done_nx  = 1'b0;
        snap_en  = 1'b0;
        acc_load = 1'b0;
        acc_add  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    snap_en  = 1'b1;
                    state_nx = ST_INIT;
                end
            end
            ST_INIT: begin
                acc_load = 1'b1;
                idx_nx   = '0;
                valid_nx = 1'b1;
                state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (accept) begin
                    if (o_ray_idx == LAST_IDX) begin
                        valid_nx = 1'b0;
                        done_nx  = 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        acc_add = 1'b1;
                        idx_nx  = o_ray_idx + LOG2_RAYS'(1);
                    end
                end
            end
            default: begin
                valid_nx = 1'b0;
                state_nx = ST_IDLE;
            end
        endcase

        busy_nx = (state_nx != ST_IDLE);
    end

    ray_dir_gen_vec2_accum #(
        .W (W)
    ) u_accum (
        .clk    (clk),
        .reset  (reset),
        .load   (acc_load),
        .add    (acc_add),
        .load_x (facing_x_q - vplane_x_q),
        .load_y (facing_y_q - vplane_y_q),
        .step_x (step_x_q),
        .step_y (step_y_q),
        .x      (o_rayX),
        .y      (o_rayY)
    );

endmodule : ray_dir_gen
